// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: owns the board, alternates X/O turns, accepts
// one move per turn over valid/ready, rejects illegal moves and detects win/draw.
module ttt_game_ctrl #(
  parameter bit FIRST_PLAYER = 1'b1,
  parameter int TIMEOUT      = 0,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        move_valid,
  input  logic [3:0]  move_pos,
  output logic        move_ready,
  output logic        move_reject,
  output logic        timeout,
  output logic        turn,
  output logic [17:0] board,
  output logic [3:0]  move_count,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        draw
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MOVE,
    CHECK,
    DONE
  } state_t;

  localparam logic [1:0] CODE_EMPTY = 2'b00;
  localparam logic [1:0] CODE_O     = 2'b01;
  localparam logic [1:0] CODE_X     = 2'b10;

  localparam bit             TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] turn_cnt;

  logic [1:0] mover_code;
  logic [1:0] target_cell;
  logic       pos_ok;
  logic       accept;
  logic       mover_wins;

  // Three in a row on any of the 8 lines for the given player code.
  function automatic logic has_line(input logic [17:0] b, input logic [1:0] code);
    logic [8:0] own;
    for (int i = 0; i < 9; i++) begin
      own[i] = (b[2*i +: 2] == code);
    end
    return (own[0] & own[1] & own[2]) |
           (own[3] & own[4] & own[5]) |
           (own[6] & own[7] & own[8]) |
           (own[0] & own[3] & own[6]) |
           (own[1] & own[4] & own[7]) |
           (own[2] & own[5] & own[8]) |
           (own[0] & own[4] & own[8]) |
           (own[2] & own[4] & own[6]);
  endfunction

  assign mover_code = turn ? CODE_X : CODE_O;
  assign pos_ok     = (move_pos <= 4'd8);

  always_comb begin
    target_cell = CODE_EMPTY;
    for (int i = 0; i < 9; i++) begin
      if (move_pos == 4'(i)) begin
        target_cell = board[2*i +: 2];
      end
    end
  end

  assign accept     = move_valid && pos_ok && (target_cell == CODE_EMPTY);
  assign mover_wins = has_line(board, mover_code);

  assign move_ready = (state == WAIT_MOVE);
  assign game_over  = (state == DONE);

  // An accepted move always takes priority over an expiring turn timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      board       <= '0;
      move_count  <= '0;
      turn        <= FIRST_PLAYER;
      winner      <= CODE_EMPTY;
      draw        <= 1'b0;
      move_reject <= 1'b0;
      timeout     <= 1'b0;
      turn_cnt    <= '0;
    end else begin
      move_reject <= 1'b0;
      timeout     <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            board      <= '0;
            move_count <= '0;
            winner     <= CODE_EMPTY;
            draw       <= 1'b0;
            turn       <= FIRST_PLAYER;
            turn_cnt   <= '0;
            state      <= WAIT_MOVE;
          end
        end
        WAIT_MOVE: begin
          if (accept) begin
            for (int i = 0; i < 9; i++) begin
              if (move_pos == 4'(i)) begin
                board[2*i +: 2] <= mover_code;
              end
            end
            move_count <= move_count + 4'd1;
            turn_cnt   <= '0;
            state      <= CHECK;
          end else if (move_valid) begin
            move_reject <= 1'b1;
          end else if (TMO_EN) begin
            if (turn_cnt == CNT_LAST) begin
              timeout  <= 1'b1;
              turn     <= ~turn;
              turn_cnt <= '0;
            end else begin
              turn_cnt <= turn_cnt + CNT_W'(1);
            end
          end
        end
        CHECK: begin
          if (mover_wins) begin
            winner <= mover_code;
            state  <= DONE;
          end else if (move_count == 4'd9) begin
            draw  <= 1'b1;
            state <= DONE;
          end else begin
            turn  <= ~turn;
            state <= WAIT_MOVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: instance a (X first, 5-cycle turn timer)
// and instance b (O first, no timer) driven with hand-checked move sequences.
module tb_ttt_game_ctrl;

  logic clk;
  logic rst;

  logic        a_start, a_valid, a_ready, a_reject, a_timeout, a_turn;
  logic        a_over, a_draw;
  logic [3:0]  a_pos, a_count;
  logic [17:0] a_board;
  logic [1:0]  a_winner;

  logic        b_start, b_valid, b_ready, b_reject, b_timeout, b_turn;
  logic        b_over, b_draw;
  logic [3:0]  b_pos, b_count;
  logic [17:0] b_board;
  logic [1:0]  b_winner;

  int vectors     = 0;
  int miscompares = 0;

  ttt_game_ctrl #(.FIRST_PLAYER(1'b1), .TIMEOUT(5), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .move_valid(a_valid), .move_pos(a_pos),
    .move_ready(a_ready), .move_reject(a_reject), .timeout(a_timeout), .turn(a_turn),
    .board(a_board), .move_count(a_count), .game_over(a_over), .winner(a_winner),
    .draw(a_draw)
  );

  ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .TIMEOUT(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .move_valid(b_valid), .move_pos(b_pos),
    .move_ready(b_ready), .move_reject(b_reject), .timeout(b_timeout), .turn(b_turn),
    .board(b_board), .move_count(b_count), .game_over(b_over), .winner(b_winner),
    .draw(b_draw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for move_ready on the selected instance, then offers one move for one cycle.
  task automatic applyStimulus(input bit sel, input logic [3:0] pos);
    int n;
    n = 0;
    @(negedge clk);
    while (((sel ? b_ready : a_ready) !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", 32'(sel ? b_ready : a_ready), 1);
    if (sel) begin
      b_valid = 1'b1;
      b_pos   = pos;
    end else begin
      a_valid = 1'b1;
      a_pos   = pos;
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) b_start = 1'b1;
    else     a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    checkOutput("rst_board", 32'(a_board), 0);
    checkOutput("rst_count", 32'(a_count), 0);
    checkOutput("rst_ready", 32'(a_ready), 0);
    checkOutput("rst_turn", 32'(a_turn), 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_valid = 1'b0; a_pos = 4'd0;
    b_start = 1'b0; b_valid = 1'b0; b_pos = 4'd0;
    $display("[TB] start");

    // Reset state
    #3;
    checkOutput("init_board", 32'(a_board), 0);
    checkOutput("init_count", 32'(a_count), 0);
    checkOutput("init_turn_a", 32'(a_turn), 1);
    checkOutput("init_turn_b", 32'(b_turn), 0);
    checkOutput("init_winner", 32'(a_winner), 0);
    checkOutput("init_flags", 32'({a_draw, a_over, a_ready, a_reject, a_timeout}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", 32'(a_ready), 0);

    // Mid-game reset after three moves
    pulse_start(1'b0);
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd4);
    applyStimulus(1'b0, 4'd8);
    checkOutput("mid_board", 32'(a_board), 'h20102);
    checkOutput("mid_count", 32'(a_count), 3);
    @(negedge clk);
    checkOutput("mid_turn", 32'(a_turn), 0);
    do_reset();
    @(negedge clk);
    checkOutput("post_rst_idle", 32'({a_ready, a_over}), 0);

    // X wins top row
    pulse_start(1'b0);
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd3);
    applyStimulus(1'b0, 4'd1);
    applyStimulus(1'b0, 4'd4);
    applyStimulus(1'b0, 4'd2);
    checkOutput("row_over_early", 32'(a_over), 0);
    @(negedge clk);
    checkOutput("row_over", 32'(a_over), 1);
    checkOutput("row_winner", 32'(a_winner), 'h2);
    checkOutput("row_draw", 32'(a_draw), 0);
    checkOutput("row_board", 32'(a_board), 'h16A);
    checkOutput("row_count", 32'(a_count), 5);
    checkOutput("row_ready", 32'(a_ready), 0);
    a_valid = 1'b1;
    a_pos   = 4'd5;
    @(negedge clk);
    a_valid = 1'b0;
    checkOutput("done_no_reject", 32'(a_reject), 0);
    checkOutput("done_board_held", 32'(a_board), 'h16A);

    // Restart from DONE, X wins anti-diagonal
    pulse_start(1'b0);
    checkOutput("restart_board", 32'(a_board), 0);
    checkOutput("restart_state", 32'({a_ready, a_over, a_winner, a_count, a_turn}), 'h101);
    applyStimulus(1'b0, 4'd2);
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd4);
    applyStimulus(1'b0, 4'd1);
    applyStimulus(1'b0, 4'd6);
    @(negedge clk);
    checkOutput("diag_winner", 32'({a_over, a_winner, a_draw}), 'b1100);

    // Occupied cell then out-of-range position: two reject pulses, nothing changes
    pulse_start(1'b0);
    applyStimulus(1'b0, 4'd4);
    @(negedge clk);
    a_valid = 1'b1;
    a_pos   = 4'd4;
    @(negedge clk);
    checkOutput("rej1_pulse", 32'(a_reject), 1);
    checkOutput("rej1_state", 32'({a_board, a_turn, a_count}), {18'h200, 1'b0, 4'd1});
    a_pos = 4'd9;
    @(negedge clk);
    checkOutput("rej2_pulse", 32'(a_reject), 1);
    checkOutput("rej2_state", 32'({a_board, a_turn, a_count}), {18'h200, 1'b0, 4'd1});
    a_valid = 1'b0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    checkOutput("rej_end", 32'(a_reject), 0);
    checkOutput("start_ignored", 32'({a_ready, a_count, a_board}), {1'b1, 4'd1, 18'h200});
    do_reset();

    // Turn timer: five idle cycles forfeit X's turn; a move on the expiring cycle wins
    a_start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) a_start = 1'b0;
      checkOutput($sformatf("tmo_pulse_%0d", k), 32'(a_timeout), (k == 6) ? 1 : 0);
      if (k == 6) checkOutput("tmo_turn", 32'(a_turn), 0);
      if (k == 10) begin
        a_valid = 1'b1;
        a_pos   = 4'd0;
      end
      if (k == 11) begin
        a_valid = 1'b0;
        checkOutput("tmo_move_board", 32'(a_board), 'h1);
        checkOutput("tmo_move_count", 32'(a_count), 1);
      end
    end
    do_reset();

    // Full board, no line: draw
    pulse_start(1'b0);
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd1);
    applyStimulus(1'b0, 4'd2);
    applyStimulus(1'b0, 4'd4);
    applyStimulus(1'b0, 4'd3);
    applyStimulus(1'b0, 4'd5);
    applyStimulus(1'b0, 4'd7);
    applyStimulus(1'b0, 4'd6);
    applyStimulus(1'b0, 4'd8);
    @(negedge clk);
    checkOutput("draw_count", 32'(a_count), 9);
    checkOutput("draw_flags", 32'({a_over, a_draw, a_winner}), 'b1100);
    checkOutput("draw_board", 32'(a_board), 'h295A6);

    // O moves first and wins the middle column
    pulse_start(1'b1);
    checkOutput("b_first_turn", 32'(b_turn), 0);
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b1, 4'd0);
    applyStimulus(1'b1, 4'd4);
    applyStimulus(1'b1, 4'd2);
    applyStimulus(1'b1, 4'd7);
    @(negedge clk);
    checkOutput("col_flags", 32'({b_over, b_winner, b_draw}), 'b1010);
    checkOutput("col_board", 32'(b_board), 'h4126);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
